// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V run controller: FSM state encoding and
// the two instruction encodings that end a program.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN_RESET   = 2'd0,
    RUN_RUN     = 2'd1,
    RUN_HALTED  = 2'd2,
    RUN_TIMEOUT = 2'd3
  } run_state_t;

  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_JAL_SELF);
  endfunction

endpackage

// File: rtl/riscv_run_ctrl_rst_stretch.sv
// Holds core_rst high after rst falls; core_rst drops on the RST_CYCLES-th
// edge that samples rst low, the same edge on which the run controller enters RUN.
module rst_stretch #(
  parameter int RST_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  output logic core_rst,
  output logic rst_done
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] LAST = RW'(RST_CYCLES - 1);

  logic [RW-1:0] rst_cnt;

  assign rst_done = core_rst && (rst_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt  <= '0;
      core_rst <= 1'b1;
    end else if (core_rst) begin
      if (rst_cnt == LAST) core_rst <= 1'b0;
      else                 rst_cnt  <= rst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller beside the core: reset stretch, cycle/instret counters, halt and
// watchdog detection, sticky verdict. Define RUN_CTRL_SIG_CHECK_EN to grade by signature.
module riscv_run_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000,
  parameter logic [XLEN-1:0] EXPECT_SIG = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst,
  input  logic             retire_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  sig_i,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  run_state_t state, state_next;
  logic rst_done;
  logic halt_ev;
  logic wd_ev;
  logic halt_pass;

  rst_stretch #(.RST_CYCLES(RST_CYCLES)) u_rst_stretch (
    .clk      (clk),
    .rst      (rst),
    .core_rst (core_rst),
    .rst_done (rst_done)
  );

  assign halt_ev = retire_i && is_halt_instr(instr_i);
  assign wd_ev   = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

`ifdef RUN_CTRL_SIG_CHECK_EN
  assign halt_pass = (sig_i == EXPECT_SIG) && (instr_i == INSTR_ECALL);
`else
  logic sig_unused;
  assign sig_unused = ^{sig_i, EXPECT_SIG};
  assign halt_pass  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= RUN_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN_RESET: if (rst_done) state_next = RUN_RUN;
      RUN_RUN: begin
        if (halt_ev)    state_next = RUN_HALTED;
        else if (wd_ev) state_next = RUN_TIMEOUT;
      end
      default: state_next = state;
    endcase
  end

  // Halt has priority over the watchdog when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      halt_pc     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else if (state == RUN_RUN) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire_i) instret_cnt <= instret_cnt + 1'b1;
      if (halt_ev) begin
        halt_pc <= pc_i;
        done    <= 1'b1;
        pass    <= halt_pass;
      end else if (wd_ev) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule
